// File: rtl/imem_ctrl.sv
// imem_ctrl: writable instruction memory with power-up clear, a one-cycle
// registered fetch port, a stall-hold output stage and fetch exception flags.
// Misaligned or out-of-range fetches return a NOP together with an exception
// code. Loader writes to illegal addresses are dropped without any flag.

module imem_ctrl #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [31:0]       imem_pc,
    input  logic              imem_stall,
    input  logic              imem_wr_en,
    input  logic [31:0]       imem_wr_addr,
    input  logic [DATA_W-1:0] imem_wr_data,
    output logic              imem_ready,
    output logic [DATA_W-1:0] imem_instruction,
    output logic              imem_valid,
    output logic [1:0]        imem_exc
);

    // Byte-address limit; one extra bit so DEPTH*4 can never wrap.
    localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
    localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic                r_ready;
    logic                r_valid;
    logic [1:0]          r_exc;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [AW-1:0]       w_rd_idx;
    logic [AW-1:0]       w_wr_idx;
    logic                w_misal;
    logic                w_range;
    logic [1:0]          w_exc;
    logic                w_accept;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_rd_idx  = imem_pc[AW+1:2];
    assign w_wr_idx  = imem_wr_addr[AW+1:2];
    assign w_rd_data = r_mem[w_rd_idx];

    // Decode fetch exceptions, fetch acceptance and loader write legality.
    always_comb begin
        w_misal  = (imem_pc[1:0] != 2'b00);
        w_range  = ({1'b0, imem_pc} >= LIMIT);
        w_exc    = {w_range, w_misal};
        w_accept = 1'b0;
        w_wr_ok  = 1'b0;
        if (r_state == READY) begin
            w_accept = imem_req && !imem_stall;
            w_wr_ok  = imem_wr_en
                       && (imem_wr_addr[1:0] == 2'b00)
                       && ({1'b0, imem_wr_addr} < LIMIT);
        end else begin
            w_accept = 1'b0;
            w_wr_ok  = 1'b0;
        end
    end

    // Clear/ready sequencer: one NOP write per cycle, then READY until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == LAST_W) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: cleared word by word during CLEAR, loader writes in READY.
    // Not reset; the clear sequence provides the known contents.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_wr_idx] <= imem_wr_data;
        end
    end

    // Output stage: hold on stall, load on accept, otherwise drop valid/exc.
    // The array read sees pre-edge contents, giving read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_exc   <= 2'b00;
            r_instr <= '0;
        end else if (imem_stall) begin
            r_valid <= r_valid;
            r_exc   <= r_exc;
            r_instr <= r_instr;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_exc   <= w_exc;
            r_instr <= (w_exc == 2'b00) ? w_rd_data : '0;
        end else begin
            r_valid <= 1'b0;
            r_exc   <= 2'b00;
        end
    end

    assign imem_ready       = r_ready;
    assign imem_valid       = r_valid;
    assign imem_exc         = r_exc;
    assign imem_instruction = r_instr;

endmodule
